// File: rtl/spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_ram_arbiter
//
// Shares one command-driven RAM between two requesters: the SPI slave path
// (requester 0) and a local host port (requester 1). The RAM keeps its write
// and read addresses as internal state, so an address word and the data word
// that follows it must come from the same requester. The grant is therefore
// locked for a whole transaction. The lock ends on a write-data word, or on the
// RAM's answer to a read-data word. Ownership alternates round-robin at
// transaction boundaries. A lock timeout frees the RAM from an owner that
// stalls.
//
// Command word: {op[1:0], payload[7:0]}
//   op 00 write-address, 01 write-data (ends lock),
//   op 10 read-address,  11 read-data (waits for RAM data, then ends lock)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0_valid/data/ready    requester 0 command stream (valid/ready handshake)
//   rsp0_valid/data          requester 0 read data, one-cycle pulse
//   req1_* / rsp1_*          same for requester 1
//   ram_din, ram_rx_valid    command word to RAM, one-cycle strobe per word
//   ram_dout, ram_tx_valid   read data returned by the RAM
//   owner                    current or last granted requester
//   busy                     a transaction currently holds the lock
//   err_timeout              one-cycle pulse when the lock is forcibly released
// -----------------------------------------------------------------------------
module spi_ram_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    input  logic [9:0] req0_data,
    output logic       req0_ready,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_data,

    input  logic       req1_valid,
    input  logic [9:0] req1_data,
    output logic       req1_ready,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_data,

    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,

    output logic       owner,
    output logic       busy,
    output logic       err_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    state_t          state, state_nxt;
    logic            owner_nxt;
    logic [TO_W-1:0] cnt, cnt_nxt;
    logic [9:0]      din_nxt;
    logic            rxv_nxt;
    logic            rsp0v_nxt, rsp1v_nxt;
    logic [7:0]      rsp0d_nxt, rsp1d_nxt;
    logic            err_nxt;

    logic            accept;
    logic [9:0]      word;
    logic            stall_expired;

    // The owner's word and handshake; only the owner ever sees ready.
    assign word          = owner ? req1_data : req0_data;
    assign accept        = (state == OWN) && (owner ? req1_valid : req0_valid);
    // cnt counts stalled cycles already spent; this is the last one allowed.
    assign stall_expired = (cnt == TO_W'(TIMEOUT - 1));

    assign req0_ready = (state == OWN) && !owner;
    assign req1_ready = (state == OWN) &&  owner;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        din_nxt   = ram_din;
        rxv_nxt   = 1'b0;
        rsp0v_nxt = 1'b0;
        rsp1v_nxt = 1'b0;
        rsp0d_nxt = rsp0_data;
        rsp1d_nxt = rsp1_data;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                // Arbitration cycle: no word is consumed. On a tie the
                // requester that did not hold the last grant wins.
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid)
                        owner_nxt = ~owner;
                    else
                        owner_nxt = req1_valid;
                    state_nxt = OWN;
                    cnt_nxt   = '0;
                end
            end

            OWN: begin
                if (accept) begin
                    din_nxt = word;
                    rxv_nxt = 1'b1;
                    cnt_nxt = '0;
                    case (word[9:8])
                        OP_WR_DATA: state_nxt = IDLE;
                        OP_RD_DATA: state_nxt = RD_WAIT;
                        default:    state_nxt = OWN;
                    endcase
                end else if (stall_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                end
            end

            RD_WAIT: begin
                if (ram_tx_valid) begin
                    if (owner) begin
                        rsp1v_nxt = 1'b1;
                        rsp1d_nxt = ram_dout;
                    end else begin
                        rsp0v_nxt = 1'b1;
                        rsp0d_nxt = ram_dout;
                    end
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (stall_expired) begin
                    // Give up on the RAM; any late answer lands in IDLE
                    // and is ignored there.
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Register stage: all outputs except ready/busy are registered. Reset also
    // clears the data registers so no stale word or response survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 1'b1;
            cnt          <= '0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp0_data    <= '0;
            rsp1_data    <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            cnt          <= cnt_nxt;
            ram_din      <= din_nxt;
            ram_rx_valid <= rxv_nxt;
            rsp0_valid   <= rsp0v_nxt;
            rsp1_valid   <= rsp1v_nxt;
            rsp0_data    <= rsp0d_nxt;
            rsp1_data    <= rsp1d_nxt;
            err_timeout  <= err_nxt;
        end
    end

endmodule
